// File: rtl/relu_arbiter.sv
// relu_arbiter: packet-locked round-robin arbiter feeding one ReLU stage through a registered output slot
`timescale 1ns/1ps
module relu_arbiter #(
    parameter int BW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [BW-1:0]    s0_data_i,
    input  logic             s0_valid_i,
    input  logic             s0_last_i,
    output logic             s0_ready_o,
    input  logic [BW-1:0]    s1_data_i,
    input  logic             s1_valid_i,
    input  logic             s1_last_i,
    output logic             s1_ready_o,
    output logic [BW-1:0]    data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             id_o,
    input  logic             ready_i,
    output logic             pkt_done_o,
    output logic [CNT_W-1:0] pkt_beats_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t           r_state;
    state_t           w_next;
    logic             r_prio;
    logic [CNT_W-1:0] r_cnt;
    logic             w_out_free;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_acc;
    logic             w_acc_last;
    logic [CNT_W-1:0] w_cnt_inc;
    assign w_out_free = !valid_o || ready_i;
    assign w_acc0     = s0_valid_i && s0_ready_o;
    assign w_acc1     = s1_valid_i && s1_ready_o;
    assign w_acc      = w_acc0 || w_acc1;
    assign w_acc_last = (w_acc0 && s0_last_i) || (w_acc1 && s1_last_i);
    assign w_cnt_inc  = &r_cnt ? r_cnt : r_cnt + 1'b1;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_next;
    end
    // Only the last beat releases a grant; a valid gap keeps it.
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (s0_valid_i && (!s1_valid_i || !r_prio)) ? GNT0 : s1_valid_i ? GNT1 : IDLE;
        else if (w_acc_last)
            w_next = IDLE;
    end
    always_comb begin
        s0_ready_o = (r_state == GNT0) && w_out_free;
        s1_ready_o = (r_state == GNT1) && w_out_free;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            id_o        <= 1'b0;
            pkt_done_o  <= 1'b0;
            pkt_beats_o <= '0;
            r_cnt       <= '0;
            r_prio      <= 1'b0;
        end else begin
            if (w_acc) begin
                data_o  <= w_acc1 ? s1_data_i : s0_data_i;
                last_o  <= w_acc1 ? s1_last_i : s0_last_i;
                id_o    <= w_acc1;
                valid_o <= 1'b1;
            end else if (w_out_free) begin
                valid_o <= 1'b0;
            end
            pkt_done_o <= w_acc_last;
            if (r_state == IDLE) r_cnt <= '0;
            else if (w_acc)      r_cnt <= w_cnt_inc;
            if (w_acc_last) begin
                pkt_beats_o <= w_cnt_inc;
                r_prio      <= w_acc0;
            end
        end
    end
endmodule

// File: tb/tb_relu_arbiter.sv
// tb_relu_arbiter: scoreboard bench for the packet round-robin ReLU arbiter
`timescale 1ns/1ps
module tb_relu_arbiter;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [31:0] s0_data = '0, s1_data = '0;
    logic               s0_valid = 1'b0, s1_valid = 1'b0;
    logic               s0_last = 1'b0, s1_last = 1'b0;
    logic               s0_ready_o, s1_ready_o;
    logic        [31:0] data_o;
    logic               valid_o, last_o, id_o, pkt_done_o;
    logic               ready_i = 1'b1;
    logic        [15:0] pkt_beats_o;
    int                 errs = 0;
    int                 checks = 0;
    int                 cyc = 0;
    int                 done_cnt = 0;
    logic        [32:0] q0[$];
    logic        [32:0] q1[$];
    int                 qpkt[$];
    int                 obs_cyc[$];
    logic               obs_id[$];
    logic               obs_last[$];
    logic        [32:0] exp_beat;
    int                 exp_pkt;
    bit                 s0_fin;
    int                 t1[4] = '{-3, 0, 5, -1};

    relu_arbiter #(.BW(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s0_data_i(s0_data), .s0_valid_i(s0_valid), .s0_last_i(s0_last), .s0_ready_o(s0_ready_o),
        .s1_data_i(s1_data), .s1_valid_i(s1_valid), .s1_last_i(s1_last), .s1_ready_o(s1_ready_o),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .id_o(id_o), .ready_i(ready_i),
        .pkt_done_o(pkt_done_o), .pkt_beats_o(pkt_beats_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Output scoreboard: beats are matched against the per-source queue named by id_o.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            checks++;
            if (id_o ? q1.size() == 0 : q0.size() == 0) begin
                errs++;
                $display("FAIL beat_unexpected id=%0d data=%0d last=%0d, no beat expected", id_o, $signed(data_o), last_o);
            end else begin
                exp_beat = id_o ? q1.pop_front() : q0.pop_front();
                if ({last_o, data_o} !== exp_beat) begin
                    errs++;
                    $display("FAIL beat id=%0d got data=%0d last=%0d expected data=%0d last=%0d",
                             id_o, $signed(data_o), last_o, $signed(exp_beat[31:0]), exp_beat[32]);
                end
            end
            obs_cyc.push_back(cyc);
            obs_id.push_back(id_o);
            obs_last.push_back(last_o);
        end
        if (rst_n && pkt_done_o) begin
            done_cnt++;
            checks++;
            if (qpkt.size() == 0) begin
                errs++;
                $display("FAIL pkt_done_unexpected beats=%0d, no packet completion expected", pkt_beats_o);
            end else begin
                exp_pkt = qpkt.pop_front();
                if (pkt_beats_o !== 16'(exp_pkt)) begin
                    errs++;
                    $display("FAIL pkt_beats got %0d expected %0d", pkt_beats_o, exp_pkt);
                end
            end
        end
    end

    task automatic set_req(input int s, input logic v, input logic [31:0] d, input logic l);
        if (s == 0) begin s0_valid = v; s0_data = d; s0_last = l; end
        else        begin s1_valid = v; s1_data = d; s1_last = l; end
    endtask

    task automatic wait_acc(input int s, output bit ok);
        logic r;
        ok = 0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            r = (s == 0) ? s0_ready_o : s1_ready_o;
            @(posedge clk);
            #1;
            ok = r;
        end
    endtask

    task automatic drive(input int s, input int n, input int seed, input int gap_at);
        logic signed [31:0] d;
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                set_req(s, 1'b0, '0, 1'b0);
                repeat (2) @(posedge clk);
                #1;
            end
            d = (seed < 0) ? t1[i] : seed + i * 37 - 50;
            set_req(s, 1'b1, d, i == n - 1);
            if (s == 0) q0.push_back({i == n - 1, d});
            else        q1.push_back({i == n - 1, d});
            wait_acc(s, ok);
            checks++;
            if (!ok) begin
                errs++;
                $display("FAIL accept_timeout src=%0d beat=%0d got no accept, required within 300 cycles", s, i);
            end else if (i == n - 1) begin
                qpkt.push_back(n);
            end
        end
        set_req(s, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 1'b0, '0, 1'b0);
        set_req(1, 1'b0, '0, 1'b0);
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        obs_cyc.delete();
        obs_id.delete();
        obs_last.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({valid_o, last_o, id_o, pkt_done_o, s0_ready_o, s1_ready_o} !== 6'b0 || data_o !== '0 || pkt_beats_o !== '0) begin
            errs++;
            $display("FAIL reset_state got valid=%0d last=%0d id=%0d done=%0d rdy=%0d%0d data=%0d beats=%0d expected all 0",
                     valid_o, last_o, id_o, pkt_done_o, s0_ready_o, s1_ready_o, data_o, pkt_beats_o);
        end
    endtask

    task automatic test_single_source();
        int d0;
        clear_obs();
        d0 = done_cnt;
        drive(0, 4, -1, -1);
        repeat (3) @(posedge clk);
        checks++;
        if (obs_id.size() != 4 || obs_id[0] !== 0 || obs_id[3] !== 0 || obs_last[2] !== 0 || obs_last[3] !== 1) begin
            errs++;
            $display("FAIL single_ids got %0d beats expected 4 beats with id 0 and last on 4th", obs_id.size());
        end
        checks++;
        if (done_cnt - d0 != 1 || pkt_beats_o !== 16'd4) begin
            errs++;
            $display("FAIL single_done got pulses=%0d beats=%0d expected pulses=1 beats=4", done_cnt - d0, pkt_beats_o);
        end
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        clear_obs();
        fork
            drive(0, 2, 100, -1);
            drive(1, 2, 200, -1);
        join
        repeat (3) @(posedge clk);
        checks++;
        if (obs_id.size() != 4) begin
            errs++;
            $display("FAIL both_count got %0d beats expected 4", obs_id.size());
        end else begin
            checks++;
            if ({obs_id[0], obs_id[1], obs_id[2], obs_id[3]} !== 4'b0011) begin
                errs++;
                $display("FAIL both_order got ids %0d%0d%0d%0d expected 0011", obs_id[0], obs_id[1], obs_id[2], obs_id[3]);
            end
            checks++;
            if (obs_cyc[1] - obs_cyc[0] != 1 || obs_cyc[2] - obs_cyc[1] != 2 || obs_cyc[3] - obs_cyc[2] != 1) begin
                errs++;
                $display("FAIL both_gap got beat gaps %0d,%0d,%0d expected 1,2,1",
                         obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1], obs_cyc[3] - obs_cyc[2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int nlast;
        logic prev;
        clear_obs();
        d0 = done_cnt;
        fork
            begin for (int p = 0; p < 6; p++) drive(0, 3, 1000 + p * 100, -1); end
            begin for (int p = 0; p < 6; p++) drive(1, 3, -2000 - p * 100, -1); end
        join
        repeat (3) @(posedge clk);
        checks++;
        if (obs_id.size() != 36 || done_cnt - d0 != 12) begin
            errs++;
            $display("FAIL b2b_count got beats=%0d pulses=%0d expected beats=36 pulses=12", obs_id.size(), done_cnt - d0);
        end
        nlast = 0;
        prev = 1'b0;
        foreach (obs_last[i]) begin
            if (obs_last[i]) begin
                if (nlast > 0) begin
                    checks++;
                    if (obs_id[i] === prev) begin
                        errs++;
                        $display("FAIL b2b_alternate packet %0d got id=%0d expected id=%0d", nlast, obs_id[i], !prev);
                    end
                end
                prev = obs_id[i];
                nlast++;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        clear_obs();
        fork
            drive(1, 8, 5000, -1);
            begin
                repeat (4) @(posedge clk);
                #1;
                ready_i = 1'b0;
                @(negedge clk);
                held = data_o;
                checks++;
                if (valid_o !== 1'b1) begin
                    errs++;
                    $display("FAIL stall_valid got %0d expected 1", valid_o);
                end
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (data_o !== held || s1_ready_o !== 1'b0) begin
                        errs++;
                        $display("FAIL stall_hold cycle %0d got data=%0d ready=%0d expected data=%0d ready=0",
                                 k, data_o, s1_ready_o, held);
                    end
                    if (k < 2) @(negedge clk);
                end
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        checks++;
        if (obs_id.size() != 8 || q1.size() != 0 || pkt_beats_o !== 16'd8) begin
            errs++;
            $display("FAIL stall_total got beats=%0d pending=%0d pkt_beats=%0d expected 8,0,8", obs_id.size(), q1.size(), pkt_beats_o);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        int d0;
        set_req(0, 1'b1, 32'd111, 1'b0);
        q0.push_back({1'b0, 32'd111});
        wait_acc(0, ok);
        set_req(0, 1'b1, 32'd222, 1'b0);
        q0.push_back({1'b0, 32'd222});
        wait_acc(0, ok);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL rstmid_accept got no accept of beat 2, required within 300 cycles");
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({valid_o, last_o, id_o, pkt_done_o, s0_ready_o, s1_ready_o} !== 6'b0 || data_o !== '0 || pkt_beats_o !== '0) begin
            errs++;
            $display("FAIL rstmid_async got valid=%0d data=%0d beats=%0d rdy0=%0d expected all 0", valid_o, data_o, pkt_beats_o, s0_ready_o);
        end
        checks++;
        if (q0.size() != 0) begin
            errs++;
            $display("FAIL rstmid_beats got %0d undelivered beats expected 0", q0.size());
        end
        set_req(0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        d0 = done_cnt;
        drive(1, 1, 700, -1);
        repeat (3) @(posedge clk);
        checks++;
        if (done_cnt - d0 != 1 || pkt_beats_o !== 16'd1) begin
            errs++;
            $display("FAIL rstmid_fresh got pulses=%0d beats=%0d expected pulses=1 beats=1", done_cnt - d0, pkt_beats_o);
        end
    endtask

    task automatic test_valid_gap();
        clear_obs();
        s0_fin = 1'b0;
        fork
            begin drive(0, 4, 300, 2); s0_fin = 1'b1; end
            begin repeat (3) @(posedge clk); #1; drive(1, 2, 400, -1); end
            begin
                while (!s0_fin) begin
                    @(negedge clk);
                    checks++;
                    if (s1_ready_o !== 1'b0) begin
                        errs++;
                        $display("FAIL gap_s1_ready got %0d expected 0 while s0 holds grant", s1_ready_o);
                    end
                end
            end
        join
        repeat (3) @(posedge clk);
        checks++;
        if (obs_id.size() != 6 || {obs_id[0], obs_id[1], obs_id[2], obs_id[3], obs_id[4], obs_id[5]} !== 6'b000011) begin
            errs++;
            $display("FAIL gap_order got %0d beats expected ids 000011", obs_id.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_both_same_cycle();
        test_back_to_back();
        test_stall();
        test_reset_mid_packet();
        test_valid_gap();
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || qpkt.size() != 0) begin
            errs++;
            $display("FAIL drain got pending q0=%0d q1=%0d pkt=%0d expected 0,0,0", q0.size(), q1.size(), qpkt.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
